// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: imem request/response, redirect, and decode-side handshake.
// Perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic [4:0]      op;
  logic            redirect_misaligned;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_flushed;

  modport master (
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, op, redirect_misaligned,
    output perf_fetched, perf_flushed
  );
  modport slave (
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, op, redirect_misaligned,
    input  perf_fetched, perf_flushed
  );
`else
  modport master (
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, op, redirect_misaligned
  );
  modport slave (
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, op, redirect_misaligned
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, in-order instruction FIFO, redirect flush.
// Optional perf counters (perf_fetched/perf_flushed) under FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 2;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [FIFO_DEPTH-1:0][XLEN-1:0] data_q, data_d, dpc_q, dpc_d, apc_q, apc_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, aw_q, aw_d, ar_q, ar_d;
  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, discard_q, discard_d;
  logic          misal_q, misal_d;
  logic          req, issue, resp_keep, resp_drop, pop;
  logic [SW-1:0] used, outstanding;

  // Stale responses still occupy credit so the FIFO can never overflow.
  assign used        = SW'(count_q) + SW'(inflight_q) + SW'(discard_q);
  assign req         = !rst && !bus.redirect && (used < SW'(FIFO_DEPTH));
  assign issue       = req && bus.imem_gnt;
  assign resp_drop   = bus.imem_rvalid && (discard_q != '0);
  assign resp_keep   = bus.imem_rvalid && (discard_q == '0);
  assign pop         = bus.inst_valid && bus.inst_ready;
  assign outstanding = SW'(discard_q) + SW'(inflight_q) + SW'(issue) - SW'(bus.imem_rvalid);

  always_comb begin
    pc_d       = pc_q;
    data_d     = data_q;
    dpc_d      = dpc_q;
    apc_d      = apc_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    aw_d       = aw_q;
    ar_d       = ar_q;
    discard_d  = discard_q;
    misal_d    = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
    count_d    = count_q + CW'(resp_keep) - CW'(pop);
    inflight_d = inflight_q + CW'(issue) - CW'(resp_keep);
    if (issue) begin
      pc_d        = pc_q + XLEN'(4);
      apc_d[aw_q] = pc_q;
      aw_d        = aw_q + AW'(1);
    end
    // Address FIFO pairs each kept response with the PC it was issued for.
    if (resp_keep) begin
      data_d[wr_q] = bus.imem_rdata;
      dpc_d[wr_q]  = apc_q[ar_q];
      wr_d         = wr_q + AW'(1);
      ar_d         = ar_q + AW'(1);
    end
    if (pop)       rd_d      = rd_q + AW'(1);
    if (resp_drop) discard_d = discard_q - CW'(1);
    if (bus.redirect) begin
      pc_d       = {bus.redirect_pc[XLEN-1:2], 2'b00};
      wr_d       = '0;
      rd_d       = '0;
      aw_d       = '0;
      ar_d       = '0;
      count_d    = '0;
      inflight_d = '0;
      discard_d  = CW'(outstanding);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      wr_q       <= '0;
      rd_q       <= '0;
      aw_q       <= '0;
      ar_q       <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      misal_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      aw_q       <= aw_d;
      ar_q       <= ar_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      misal_q    <= misal_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    dpc_q  <= dpc_d;
    apc_q  <= apc_d;
  end

  assign bus.imem_req            = req;
  assign bus.imem_addr           = pc_q;
  assign bus.inst_valid          = (count_q != '0);
  assign bus.inst                = bus.inst_valid ? data_q[rd_q] : '0;
  assign bus.inst_pc             = bus.inst_valid ? dpc_q[rd_q] : '0;
  assign bus.op                  = bus.inst[6:2];
  assign bus.redirect_misaligned = misal_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   fetched_q, fetched_d, flushed_q, flushed_d;
  logic [SW-1:0] cancelled;

  // The redirect-cycle pop is a real delivery, not a flushed entry.
  assign cancelled = SW'(count_q) + SW'(inflight_q) - SW'(pop);

  always_comb begin
    fetched_d = fetched_q + 32'(pop);
    flushed_d = flushed_q;
    if (bus.redirect) flushed_d = flushed_q + 32'(cancelled);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign bus.perf_fetched = fetched_q;
  assign bus.perf_flushed = flushed_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus redirect/misalign/perf sequences.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus ();
  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0063 ^ (a << 8);
  endfunction

  // Memory model: in-order responses, latency captured per grant.
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pq[$];
  int cyc = 0;
  int lat = 1;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst) pq.delete();
      else if (bus.imem_req && bus.imem_gnt) pq.push_back('{bus.imem_addr, cyc + lat});
      @(posedge clk); #1;
      if (!rst && pq.size() > 0 && pq[0].due <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(pq[0].addr);
        void'(pq.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Leaves the caller at the start of the first post-reset cycle.
  task automatic do_reset();
    next_cycle();
    rst = 1'b1; bus.redirect = 1'b0; bus.inst_ready = 1'b0; lat = 1;
    next_cycle();
    @(negedge clk);
    chk("rst_req",   bus.imem_req,            1'b0);
    chk("rst_valid", bus.inst_valid,          1'b0);
    chk("rst_inst",  bus.inst,                32'h0);
    chk("rst_pc",    bus.inst_pc,             32'h0);
    chk("rst_op",    bus.op,                  5'h0);
    chk("rst_misal", bus.redirect_misaligned, 1'b0);
    next_cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t tv[16];

  initial begin
    int pops;
    rst = 1'b1;
    bus.imem_gnt    = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b0;

    // gnt=1, latency 1; ready low for rows 7..12 to fill the FIFO.
    tv[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tv[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tv[2]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    tv[3]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    tv[4]  = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
    tv[5]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
    tv[6]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
    tv[7]  = '{1'b0, 1'b1, 32'h14, 1'b0, 32'h00};
    tv[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    tv[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    tv[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    tv[11] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    tv[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    tv[13] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
    tv[14] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h14};
    tv[15] = '{1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.inst_ready = tv[i].ready;
      @(negedge clk);
      chk($sformatf("tv%0d_req", i),   bus.imem_req,   tv[i].exp_req);
      chk($sformatf("tv%0d_valid", i), bus.inst_valid, tv[i].exp_valid);
      if (tv[i].exp_req)
        chk($sformatf("tv%0d_addr", i), bus.imem_addr, tv[i].exp_addr);
      if (tv[i].exp_valid) begin
        chk($sformatf("tv%0d_pc", i),   bus.inst_pc, tv[i].exp_pc);
        chk($sformatf("tv%0d_inst", i), bus.inst,    mem_word(tv[i].exp_pc));
        chk($sformatf("tv%0d_op", i),   bus.op,      5'b11000);
      end
      next_cycle();
    end

    // Latency 3, redirect to 0x100 with two requests in flight.
    do_reset();
    lat = 3; bus.inst_ready = 1'b1;
    @(negedge clk); chk("A_c0_addr", bus.imem_addr, 32'h0); chk("A_c0_req", bus.imem_req, 1'b1);
    next_cycle();
    @(negedge clk); chk("A_c1_addr", bus.imem_addr, 32'h4); chk("A_c1_req", bus.imem_req, 1'b1);
    next_cycle();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    @(negedge clk); chk("A_c2_req", bus.imem_req, 1'b0);
    next_cycle();
    bus.redirect = 1'b0;
    @(negedge clk); chk("A_c3_req", bus.imem_req, 1'b0); chk("A_c3_valid", bus.inst_valid, 1'b0);
    next_cycle();
    @(negedge clk); chk("A_c4_req", bus.imem_req, 1'b1); chk("A_c4_addr", bus.imem_addr, 32'h100);
    chk("A_c4_valid", bus.inst_valid, 1'b0);
    for (int k = 0; k < 20 && !bus.inst_valid; k++) begin
      next_cycle();
      @(negedge clk);
    end
    chk("A_wait_valid", bus.inst_valid, 1'b1);
    chk("A_pc",      bus.inst_pc, 32'h100);
    chk("A_inst",    bus.inst,    mem_word(32'h100));
    chk("A_discard", 32'(dut.discard_q), 32'h0);
    next_cycle();

    // Redirect coinciding with a pop and an outstanding grant; misaligned target.
    do_reset();
    lat = 1; bus.inst_ready = 1'b1;
    @(negedge clk); chk("B_c0_addr", bus.imem_addr, 32'h0);
    next_cycle();
    lat = 3;
    @(negedge clk); chk("B_c1_addr", bus.imem_addr, 32'h4);
    next_cycle();
    lat = 1; bus.redirect = 1'b1; bus.redirect_pc = 32'h103;
    @(negedge clk);
    chk("B_c2_valid", bus.inst_valid, 1'b1);
    chk("B_c2_pc",    bus.inst_pc,    32'h0);
    chk("B_c2_req",   bus.imem_req,   1'b0);
    chk("B_c2_misal", bus.redirect_misaligned, 1'b0);
    next_cycle();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("B_c3_valid", bus.inst_valid, 1'b0);
    chk("B_c3_req",   bus.imem_req,   1'b1);
    chk("B_c3_addr",  bus.imem_addr,  32'h100);
    chk("B_c3_misal", bus.redirect_misaligned, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("B_c4_misal", bus.redirect_misaligned, 1'b0);
    chk("B_c4_valid", bus.inst_valid, 1'b0);
    chk("B_c4_req",   bus.imem_req,   1'b0);
    next_cycle();
    @(negedge clk);
    chk("B_c5_valid", bus.inst_valid, 1'b0);
    chk("B_c5_addr",  bus.imem_addr,  32'h104);
    next_cycle();
    @(negedge clk);
    chk("B_c6_valid", bus.inst_valid, 1'b1);
    chk("B_c6_pc",    bus.inst_pc,    32'h100);
    chk("B_c6_inst",  bus.inst,       mem_word(32'h100));
    next_cycle();

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    @(negedge clk);
    chk("P_rst_fetched", bus.perf_fetched, 32'h0);
    chk("P_rst_flushed", bus.perf_flushed, 32'h0);
    pops = 0;
    for (int k = 0; k < 60 && pops < 5; k++) begin
      next_cycle();
      bus.inst_ready = 1'b1;
      @(negedge clk);
      if (bus.inst_valid && bus.inst_ready) pops++;
    end
    chk("P_pops_seen", 32'(pops), 32'd5);
    next_cycle();
    bus.inst_ready = 1'b0;
    for (int k = 0; k < 6; k++) next_cycle();
    @(negedge clk);
    chk("P_full_valid", bus.inst_valid, 1'b1);
    chk("P_full_req",   bus.imem_req,   1'b0);
    next_cycle();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    next_cycle();
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("P_fetched", bus.perf_fetched, 32'd5);
    chk("P_flushed", bus.perf_flushed, 32'd2);
`else
    pops = 0;
    chk("no_perf_pops", 32'(pops), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
